// File: rtl/reloj_pkg.sv
// reloj_pkg
//   Shared definitions for the 24-hour clock controller.
//   - mode_t   : operating mode encoding driven on the `mode` output
//                (RUN = 00, SET_H = 01, SET_M = 10; 11 is never used).
//   - HOUR_MAX : largest legal hour value (23).
//   - MIN_MAX  : largest legal minute value (59).
//   - SEC_MAX  : largest legal second value (59).
package reloj_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } mode_t;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Free-running prescaler counting 0..CLK_HZ-1. Produces two enables in
//   the clock domain; no derived clocks are generated.
//
// Parameters
//   CLK_HZ  input clock frequency in Hz (even, >= 4)
//
// Ports
//   clock   system clock, rising edge active
//   rst_n   asynchronous active-low reset (release already synchronized)
//   clr     synchronous restart: the next cycle starts at count 0
//   tick    1 exactly in the cycle where count == CLK_HZ-1
//   half    1 exactly in the cycle where count == CLK_HZ/2-1, i.e. the
//           last cycle of the first half-second
module tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic half
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST      = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HZ / 2 - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_comb begin
    count_nxt = count + CW'(1);
    if (clr || (count == LAST)) begin
      count_nxt = '0;
    end
  end

  // tick and half are registered from the next count so they line up
  // with the count value they describe, not one cycle late.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
      half  <= 1'b0;
    end else begin
      count <= count_nxt;
      tick  <= (count_nxt == LAST);
      half  <= (count_nxt == HALF_LAST);
    end
  end

endmodule

// File: rtl/reloj_control.sv
// reloj_control
//   24-hour clock with a three-mode setting FSM (RUN -> SET_H -> SET_M).
//   In RUN the time advances once per second with full carry chain; in the
//   SET modes time is frozen and btn_inc bumps the selected field without
//   carry. Leaving SET_M clears seconds and restarts the prescaler so the
//   first second after setting is a full second.
//
// Parameters
//   CLK_HZ    input clock frequency in Hz (even, >= 4)
//
// Ports
//   clock     system clock, rising edge active
//   reset_n   asynchronous active-low reset; assertion is immediate,
//             release is synchronized internally
//   btn_mode  one-cycle pulse, advances the mode
//   btn_inc   one-cycle pulse, increments the field being edited
//   hours     current hour 0..23 (registered)
//   minutes   current minute 0..59 (registered)
//   seconds   current second 0..59 (registered)
//   mode      00 RUN, 01 SET_H, 10 SET_M (registered)
//   blink     blink enable for the edited field, high in the first half
//             of each second while in a SET mode (registered)
//   tick_1hz  one-cycle pulse every CLK_HZ cycles
module reloj_control
  import reloj_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       tick_1hz
);

  // Wrap-around increments. The >= compare also pulls any out-of-range
  // value straight back to 0 so illegal values cannot persist.
  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_sexa(input logic [5:0] v,
                                          input logic [5:0] vmax);
    return (v >= vmax) ? 6'd0 : v + 6'd1;
  endfunction

  // Reset synchronizer: asserts asynchronously, releases two edges later.
  logic [1:0] rst_sync;
  logic       rst_n_i;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_i = rst_sync[1];

  logic tick;
  logic half;
  logic restart;

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clock(clock),
    .rst_n(rst_n_i),
    .clr  (restart),
    .tick (tick),
    .half (half)
  );

  assign tick_1hz = tick;

  mode_t      state;
  mode_t      state_nxt;
  logic [4:0] hours_nxt;
  logic [5:0] minutes_nxt;
  logic [5:0] seconds_nxt;
  logic       hi_phase;
  logic       hi_nxt;
  logic       blink_nxt;

  assign mode = state;

  always_comb begin
    state_nxt   = state;
    hours_nxt   = hours;
    minutes_nxt = minutes;
    seconds_nxt = seconds;
    restart     = 1'b0;

    if (btn_mode) begin
      case (state)
        RUN:   state_nxt = SET_H;
        SET_H: state_nxt = SET_M;
        SET_M: begin
          state_nxt   = RUN;
          seconds_nxt = 6'd0;
          restart     = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end

    // btn_mode takes priority, so btn_inc only acts when btn_mode is low.
    case (state)
      RUN: begin
        if (tick) begin
          seconds_nxt = inc_sexa(seconds, SEC_MAX);
          if (seconds >= SEC_MAX) begin
            minutes_nxt = inc_sexa(minutes, MIN_MAX);
            if (minutes >= MIN_MAX) begin
              hours_nxt = inc_hour(hours);
            end
          end
        end
      end
      SET_H: begin
        if (btn_inc && !btn_mode) begin
          hours_nxt = inc_hour(hours);
        end
      end
      SET_M: begin
        if (btn_inc && !btn_mode) begin
          minutes_nxt = inc_sexa(minutes, MIN_MAX);
        end
      end
      default: ;
    endcase

    // hi_phase mirrors "prescaler count < CLK_HZ/2" for the next cycle,
    // reconstructed from the two enables: a wrap or restart enters the
    // first half, the half pulse leaves it.
    hi_nxt = hi_phase;
    if (restart || tick) begin
      hi_nxt = 1'b1;
    end else if (half) begin
      hi_nxt = 1'b0;
    end

    blink_nxt = (state_nxt != RUN) && hi_nxt;
  end

  always_ff @(posedge clock or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= RUN;
      hours    <= 5'd0;
      minutes  <= 6'd0;
      seconds  <= 6'd0;
      hi_phase <= 1'b1;
      blink    <= 1'b0;
    end else begin
      state    <= state_nxt;
      hours    <= hours_nxt;
      minutes  <= minutes_nxt;
      seconds  <= seconds_nxt;
      hi_phase <= hi_nxt;
      blink    <= blink_nxt;
    end
  end

endmodule

// File: tb/tb_reloj_control.sv
module tb_reloj_control;

  localparam int HZ = 10;

  localparam int K_H  = 0;
  localparam int K_M  = 1;
  localparam int K_S  = 2;
  localparam int K_MD = 3;
  localparam int K_BL = 4;
  localparam int K_TK = 5;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;
  logic       tick_1hz;

  reloj_control #(.CLK_HZ(HZ)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds),
    .mode    (mode),
    .blink   (blink),
    .tick_1hz(tick_1hz)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    kind;
    int    val;
    string nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   nchk = 0;
  int   nerr = 0;
  int   anchor = 0;

  function automatic int act(input int k);
    case (k)
      K_H:     return int'(hours);
      K_M:     return int'(minutes);
      K_S:     return int'(seconds);
      K_MD:    return int'(mode);
      K_BL:    return int'(blink);
      K_TK:    return int'(tick_1hz);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input int a, input int w);
    nchk++;
    if (a != w) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, a, w);
    end
  endtask

  task automatic push(input int at, input int kind, input int val, input string nm);
    exp_t e;
    int   i;
    e.at = at; e.kind = kind; e.val = val; e.nm = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endtask

  task automatic push_time(input int at, input int h, input int m, input int s, input string nm);
    push(at, K_H, h, {nm, "_hours"});
    push(at, K_M, m, {nm, "_minutes"});
    push(at, K_S, s, {nm, "_seconds"});
  endtask

  function automatic int cnt_at(input int c);
    return (c - anchor) % HZ;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step(1);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  // Scoreboard monitor: compare every expectation due in this cycle.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at < cyc) begin
        nchk++;
        nerr++;
        $display("FAIL %s missed: due cycle %0d, now %0d", mon_e.nm, mon_e.at, cyc);
      end else begin
        chk(mon_e.nm, act(mon_e.kind), mon_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int x;
    int x2;

    reset_n  = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(3);
    push_time(cyc, 0, 0, 0, "reset");
    push(cyc, K_MD, 0, "reset_mode");
    push(cyc, K_BL, 0, "reset_blink");
    push(cyc, K_TK, 0, "reset_tick");

    // Release; synchronized release makes the first counting cycle rel+2.
    rel = cyc;
    reset_n = 1'b1;
    anchor = rel + 2;
    for (int i = 0; i <= 100; i++)
      push(rel + 1 + i, K_TK, (i > 0 && i % 10 == 0) ? 1 : 0, "tick_after_release");
    push(rel + 101, K_S, 9, "run_99_cycles_seconds");
    push_time(rel + 102, 0, 0, 10, "run_100");
    push(rel + 102, K_MD, 0, "run_100_mode");
    push(rel + 102, K_BL, 0, "run_100_blink");
    step(102);

    // btn_mode and btn_inc together in RUN: mode wins.
    pulse(1'b1, 1'b1);
    push(cyc, K_MD, 1, "mode_inc_same_cycle_mode");
    push_time(cyc, 0, 0, 10, "mode_inc_same_cycle");

    // Frozen time, running prescaler, 5/5 blink in SET_H.
    for (int k = 0; k < 20; k++) begin
      push(cyc + k, K_BL, (cnt_at(cyc + k) < HZ / 2) ? 1 : 0, "set_h_blink");
      push(cyc + k, K_TK, (cnt_at(cyc + k) == HZ - 1) ? 1 : 0, "set_h_tick");
      push(cyc + k, K_S, 10, "set_h_frozen_seconds");
    end
    step(20);

    for (int n = 1; n <= 25; n++) begin
      pulse(1'b0, 1'b1);
      if (n == 23) push(cyc, K_H, 23, "inc_hours_23");
      if (n == 24) push(cyc, K_H, 0, "inc_hours_wrap");
      if (n == 25) begin
        push(cyc, K_H, 1, "inc_hours_25");
        push(cyc, K_MD, 1, "inc_hours_mode");
      end
      step(1);
    end

    pulse(1'b1, 1'b0);
    push(cyc, K_MD, 2, "enter_set_m_mode");
    for (int n = 1; n <= 61; n++) begin
      pulse(1'b0, 1'b1);
      if (n == 59) push(cyc, K_M, 59, "inc_minutes_59");
      if (n == 60) push(cyc, K_M, 0, "inc_minutes_wrap");
      if (n == 61) begin
        push(cyc, K_M, 1, "inc_minutes_61");
        push(cyc, K_H, 1, "inc_minutes_no_carry_hours");
      end
      step(1);
    end

    // Exit SET_M at an arbitrary phase.
    step(3);
    pulse(1'b1, 1'b0);
    x = cyc;
    anchor = x;
    push(x, K_MD, 0, "exit_set_m_mode");
    push_time(x, 1, 1, 0, "exit_set_m");
    for (int k = 0; k <= 10; k++) begin
      push(x + k, K_TK, (k == HZ - 1) ? 1 : 0, "tick_after_exit");
      push(x + k, K_BL, 0, "run_blink");
    end
    push(x + 9, K_S, 0, "exit_before_first_tick");
    push(x + 10, K_S, 1, "exit_first_tick");
    step(11);

    // Preload 23:59, then run up to the midnight wrap.
    pulse(1'b1, 1'b0);
    for (int n = 1; n <= 22; n++) begin
      pulse(1'b0, 1'b1);
      step(1);
    end
    push(cyc, K_H, 23, "preload_hours");
    pulse(1'b1, 1'b0);
    for (int n = 1; n <= 58; n++) begin
      pulse(1'b0, 1'b1);
      step(1);
    end
    push(cyc, K_M, 59, "preload_minutes");
    pulse(1'b1, 1'b0);
    x2 = cyc;
    anchor = x2;
    push_time(x2, 23, 59, 0, "preload");
    push(x2, K_MD, 0, "preload_mode");
    push_time(x2 + 580, 23, 59, 58, "run_to_58");
    push(x2 + 589, K_TK, 1, "tick_59");
    push(x2 + 589, K_S, 58, "tick_59_before");
    push_time(x2 + 590, 23, 59, 59, "after_tick_59");
    push(x2 + 590, K_TK, 0, "after_tick_59_tick");
    push(x2 + 599, K_TK, 1, "tick_wrap");
    push_time(x2 + 599, 23, 59, 59, "before_wrap");
    push_time(x2 + 600, 0, 0, 0, "midnight_wrap");
    step(100);
    pulse(1'b0, 1'b1);
    push_time(cyc, 23, 59, 10, "inc_ignored_in_run");
    push(cyc, K_MD, 0, "inc_ignored_mode");
    step(x2 + 601 - cyc);

    // Set 12:34 and reset asynchronously in the middle of SET_M.
    pulse(1'b1, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      pulse(1'b0, 1'b1);
      step(1);
    end
    pulse(1'b1, 1'b0);
    for (int n = 1; n <= 34; n++) begin
      pulse(1'b0, 1'b1);
      step(1);
    end
    push(cyc, K_H, 12, "preset_hours");
    push(cyc, K_M, 34, "preset_minutes");
    push(cyc, K_MD, 2, "preset_mode");
    #6;
    reset_n = 1'b0;
    #1;
    chk("async_reset_hours", int'(hours), 0);
    chk("async_reset_minutes", int'(minutes), 0);
    chk("async_reset_seconds", int'(seconds), 0);
    chk("async_reset_mode", int'(mode), 0);
    chk("async_reset_blink", int'(blink), 0);
    chk("async_reset_tick", int'(tick_1hz), 0);
    step(2);
    push_time(cyc, 0, 0, 0, "reset_held");
    push(cyc, K_MD, 0, "reset_held_mode");

    rel = cyc;
    reset_n = 1'b1;
    anchor = rel + 2;
    for (int i = 0; i <= 12; i++)
      push(rel + 1 + i, K_TK, (i == 10) ? 1 : 0, "tick_after_second_release");
    push(rel + 12, K_S, 1, "second_release_first_second");
    step(14);

    step(2);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      nchk++;
      nerr++;
      $display("FAIL %s never checked (due cycle %0d)", mon_e.nm, mon_e.at);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
